// File: rtl/knn_pkg.sv
// knn_pkg: definitions shared by the KNN pipeline stages.
//   num_classes(type_w) : number of class types for a given type width
//   vote_w(k)           : width of a vote counter able to hold 0..k
//   rank_w(k)           : width of a rank index 0..k-1 (at least 1 bit)
//   state_t             : knn_vote FSM state encoding
//   PAD_FILL            : all-ones sorter padding pattern, sliced to the distance width
package knn_pkg;

    function automatic int num_classes(input int type_w);
        return 1 << type_w;
    endfunction

    function automatic int vote_w(input int k);
        return $clog2(k + 1);
    endfunction

    function automatic int rank_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_DECIDE = 2'd2
    } state_t;

    localparam logic [63:0] PAD_FILL = '1;

endpackage

// File: rtl/knn_vote_argmax.sv
// knn_vote_argmax: combinational winner selection over the per-class vote counters.
//   votes[c]      in  : votes collected by class c
//   first_rank[c] in  : rank of the first entry of class c (only meaningful when votes[c] != 0)
//   win_class     out : class with most votes; ties go to the smaller first_rank,
//                       then to the lower class index
//   win_votes     out : vote count of win_class (0 only when no class received a vote)
module knn_vote_argmax
    import knn_pkg::*;
#(
    parameter int TYPE_W = 3,
    parameter int K      = 5
) (
    input  logic [vote_w(K)-1:0] votes      [num_classes(TYPE_W)],
    input  logic [rank_w(K)-1:0] first_rank [num_classes(TYPE_W)],
    output logic [TYPE_W-1:0]    win_class,
    output logic [vote_w(K)-1:0] win_votes
);

    localparam int NC = num_classes(TYPE_W);
    localparam int RW = rank_w(K);

    logic [RW-1:0] best_rank;

    // Scanning classes in ascending order and replacing only on a strict
    // improvement leaves the lower class index in place on a full tie.
    // Zero-vote classes never replace, so class 0 / 0 votes is the result
    // only when nothing voted.
    always_comb begin
        win_class = '0;
        win_votes = '0;
        best_rank = '1;
        for (int c = 0; c < NC; c++) begin
            if ((votes[c] > win_votes) ||
                (votes[c] == win_votes && votes[c] != '0 && first_rank[c] < best_rank)) begin
                win_class = TYPE_W'(c);
                win_votes = votes[c];
                best_rank = first_rank[c];
            end
        end
    end

endmodule

// File: rtl/knn_vote.sv
// knn_vote: majority-vote classifier at the tail of the KNN pipeline.
// Takes a sorted distance/type vector, votes over the K nearest entries and
// reports the winning class, its vote count and the nearest distance.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : one-cycle pulse, vector present on in/in_type
//   ascending     : sort order of the vector, sampled on accept
//   in, in_type   : N distances / N class types, entry i at slice i
//   in_ready      : high while idle; vector accepted on in_valid & in_ready
//   result_valid  : one-cycle pulse, result fields valid (they hold until the next pulse)
//   result_class  : winning class
//   result_votes  : votes for the winning class
//   nearest_dist  : distance of the nearest counted entry
//   overrun       : sticky, a vector arrived while busy (cleared only by rst)
// Build option: KNN_VOTE_PAD_SKIP_EN makes all-ones distances (sorter padding)
// cast no vote; when every entry is padding the result is class 0, 0 votes,
// nearest_dist all-ones.
module knn_vote
    import knn_pkg::*;
#(
    parameter int L      = 5,
    parameter int W      = 16,
    parameter int TYPE_W = 3,
    parameter int K      = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     ascending,
    input  logic [W*(1<<L)-1:0]      in,
    input  logic [TYPE_W*(1<<L)-1:0] in_type,
    output logic                     in_ready,
    output logic                     result_valid,
    output logic [TYPE_W-1:0]        result_class,
    output logic [vote_w(K)-1:0]     result_votes,
    output logic [W-1:0]             nearest_dist,
    output logic                     overrun
);

    localparam int N  = 1 << L;
    localparam int NC = num_classes(TYPE_W);
    localparam int VW = vote_w(K);
    localparam int RW = rank_w(K);
    localparam logic [W-1:0] PAD = PAD_FILL[W-1:0];

    state_t            state;
    logic [W-1:0]      dist_q     [K];
    logic [TYPE_W-1:0] type_q     [K];
    logic [VW-1:0]     votes      [NC];
    logic [RW-1:0]     first_rank [NC];
    logic [NC-1:0]     seen;
    logic [RW-1:0]     rank_idx;
    logic [W-1:0]      near_q;
    logic [TYPE_W-1:0] win_class;
    logic [VW-1:0]     win_votes;
    logic [W-1:0]      cur_dist;
    logic [TYPE_W-1:0] cur_type;
    logic              accept;
`ifdef KNN_VOTE_PAD_SKIP_EN
    logic              found;
    logic              cur_pad;
`endif

    // Entries outside the K-wide window are legitimately ignored.
    logic unused_inputs;
    assign unused_inputs = ^{in, in_type};

    assign accept   = in_valid && in_ready;
    assign cur_dist = dist_q[rank_idx];
    assign cur_type = type_q[rank_idx];
`ifdef KNN_VOTE_PAD_SKIP_EN
    assign cur_pad  = (cur_dist == PAD);
`endif

    // Capture the K nearest entries in rank order; a descending vector has
    // its nearest entry at the top index, so the window is read backwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                if (ascending) begin
                    dist_q[i] <= in[W*i +: W];
                    type_q[i] <= in_type[TYPE_W*i +: TYPE_W];
                end else begin
                    dist_q[i] <= in[W*(N-1-i) +: W];
                    type_q[i] <= in_type[TYPE_W*(N-1-i) +: TYPE_W];
                end
            end
        end
    end

    knn_vote_argmax #(
        .TYPE_W (TYPE_W),
        .K      (K)
    ) u_argmax (
        .votes      (votes),
        .first_rank (first_rank),
        .win_class  (win_class),
        .win_votes  (win_votes)
    );

    // Control FSM: IDLE accepts, COUNT walks one rank per cycle, DECIDE
    // registers the argmax result. in_ready is registered and mirrors IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b1;
            result_valid <= 1'b0;
            result_class <= '0;
            result_votes <= '0;
            nearest_dist <= '0;
            overrun      <= 1'b0;
            rank_idx     <= '0;
            near_q       <= '0;
            seen         <= '0;
            for (int c = 0; c < NC; c++) begin
                votes[c]      <= '0;
                first_rank[c] <= '0;
            end
`ifdef KNN_VOTE_PAD_SKIP_EN
            found        <= 1'b0;
`endif
        end else begin
            result_valid <= 1'b0;
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_COUNT;
                        in_ready <= 1'b0;
                        rank_idx <= '0;
                        near_q   <= PAD;
                        seen     <= '0;
                        for (int c = 0; c < NC; c++) begin
                            votes[c]      <= '0;
                            first_rank[c] <= '0;
                        end
`ifdef KNN_VOTE_PAD_SKIP_EN
                        found    <= 1'b0;
`endif
                    end
                end
                ST_COUNT: begin
`ifdef KNN_VOTE_PAD_SKIP_EN
                    // Padding entries are invisible: no vote, no rank, no distance.
                    if (!cur_pad) begin
                        votes[cur_type] <= votes[cur_type] + VW'(1);
                        if (!seen[cur_type]) begin
                            first_rank[cur_type] <= rank_idx;
                            seen[cur_type]       <= 1'b1;
                        end
                        if (!found) begin
                            near_q <= cur_dist;
                            found  <= 1'b1;
                        end
                    end
`else
                    votes[cur_type] <= votes[cur_type] + VW'(1);
                    if (!seen[cur_type]) begin
                        first_rank[cur_type] <= rank_idx;
                        seen[cur_type]       <= 1'b1;
                    end
                    if (rank_idx == '0) begin
                        near_q <= cur_dist;
                    end
`endif
                    if (rank_idx == RW'(K-1)) begin
                        state <= ST_DECIDE;
                    end else begin
                        rank_idx <= rank_idx + RW'(1);
                    end
                end
                ST_DECIDE: begin
                    result_valid <= 1'b1;
                    result_class <= win_class;
                    result_votes <= win_votes;
                    nearest_dist <= near_q;
                    state        <= ST_IDLE;
                    in_ready     <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/knn_vote.md
# knn_vote

Majority-vote classifier that consumes the sorted distance/type vector produced by the bitonic distance sorter. It picks the K nearest entries and counts one vote per class type. It then emits the winning class, its vote count and the nearest distance. It sits directly after the sorter at the tail of the KNN pipeline.

## Interface
- L, 5, log2 of vector length N = 1<<L
- W, 16, distance width
- TYPE_W, 3, class-type width; NUM_CLASSES = 1<<TYPE_W
- K, 5, neighbours voted; legal range 1 <= K <= N
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  one-cycle pulse: sorted vector present on in/in_type
- ascending  in  1  sort order of the vector; sampled on accept
- in  in  W*N  sorted distances, entry i at [W*(i+1)-1:W*i]
- in_type  in  TYPE_W*N  class of each entry, same packing
- in_ready  out  1  high in IDLE; vector accepted when in_valid & in_ready
- result_valid  out  1  one-cycle pulse, result fields valid
- result_class  out  TYPE_W  winning class
- result_votes  out  clog2(K+1)  votes for winning class
- nearest_dist  out  W  distance of nearest counted entry
- overrun  out  1  sticky: in_valid seen while in_ready low

## Operation
- Accept: capture entries 0..K-1 when ascending=1, or entries N-1 down to N-K when ascending=0. Store them into a rank-ordered K-deep register, rank 0 = nearest. Clear all vote counters and first-rank registers.
- FSM IDLE -> COUNT -> DECIDE -> IDLE.
  - IDLE: in_ready=1.
  - COUNT: lasts K cycles. Rank index r runs 0..K-1, one entry per cycle. votes[type]++. If the class is seen for the first time, first_rank[type]=r. nearest_dist is latched from rank 0.
  - DECIDE: one cycle. Argmax over votes. On equal votes the smaller first_rank wins; on further ties the lower class index wins. The result is registered. Next state is IDLE.
- Vote counters are clog2(K+1) bits wide and cannot overflow. first_rank is clog2(K) bits; an "unseen" flag is kept per class.
- Classes with 0 votes never win unless all classes have 0 votes; that case is possible only under the macro.
- in_valid while not in_ready: the vector is dropped and overrun is set. The current operation is unaffected. overrun clears only on rst.
- Simultaneous result_valid and a new in_valid: accepted, because the FSM is already in IDLE.

## Timing
- Reset values: in_ready=1, result_valid=0, result_class=0, result_votes=0, nearest_dist=0, overrun=0, FSM=IDLE.
- Accept in cycle 0. COUNT occupies cycles 1..K. DECIDE is cycle K+1. result_valid=1 in cycle K+2, with in_ready=1 in the same cycle.
- Latency is K+2 cycles; sustained throughput is one vector per K+2 cycles.
- Result fields hold until the next result_valid.
- rst mid-operation aborts without a result_valid pulse. in_ready=1 in the cycle after rst deasserts.

## Configuration
- KNN_VOTE_PAD_SKIP_EN defined: entries whose distance equals {W{1'b1}} are treated as sorter padding.
  - They cast no vote and do not set first_rank.
  - nearest_dist takes the first non-padding entry.
  - If all K entries are padding: result_class=0, result_votes=0, nearest_dist={W{1'b1}}.
  - Latency is unchanged.
- Undefined: every entry votes regardless of value.

## Structure
- knn_pkg holds NUM_CLASSES, the vote and rank width functions, the FSM state encoding and the padding constant. The sorter-side stages share the same package.
- One sub-module: knn_vote_argmax, combinational. It takes votes[] and first_rank[] and returns the winning class and count with the tie-break above. It is instantiated once, in DECIDE.

## Test plan
Parameters: L=3, W=16, TYPE_W=3, K=5.
- Ascending order, in_type[0..4] = 2,5,2,7,2, in[0]=0x0003 -> result_class=2, result_votes=3, nearest_dist=0x0003, result_valid in cycle 7 after accept.
- Descending order, in_type[7..3] = 4,4,1,1,6, in[7]=0x0011 -> result_class=4, result_votes=2, nearest_dist=0x0011.
- Tie, ascending, types by rank 3,5,5,3,1 -> 3 and 5 both have 2 votes; rank 0 is class 3 -> result_class=3, result_votes=2.
- in_valid pulsed in cycle 2 of an operation -> overrun=1 and stays 1. The first result is unchanged, and exactly one result_valid pulse occurs.
- rst asserted during COUNT -> no result_valid pulse, all outputs at reset values, and a new vector accepted in the cycle after rst deasserts.
- Padding case: distances by rank 0x0010,0xFFFF,0xFFFF,0xFFFF,0xFFFF with types 4,1,1,1,1.
  - With KNN_VOTE_PAD_SKIP_EN: result_class=4, result_votes=1.
  - Without it: result_class=1, result_votes=4.
